// File: rtl/regbank_dump_tx_if.sv
// Byte stream handshake carrying the register dump.
// The producer drives o_data/o_valid; the consumer drives i_ready.
interface regbank_dump_tx_if;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;

  modport master (
    output o_data,
    output o_valid,
    input  i_ready
  );

  modport slave (
    input  o_data,
    input  o_valid,
    output i_ready
  );
endinterface

// File: rtl/regbank_dump_tx.sv
// Snapshots the flat register debug bus and streams it out as bytes.
// Register 0 first, least-significant byte first within each register.
module regbank_dump_tx #(
  parameter int SIZE          = 32,
  parameter int NUM_REGISTERS = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic                          i_abort,
  input  logic [SIZE*NUM_REGISTERS-1:0] i_registers_debug,
  regbank_dump_tx_if.master             tx,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [$clog2(NUM_REGISTERS)-1:0] o_reg_idx
);

  localparam int BYTES_PER_REG = SIZE / 8;
  localparam int SIZE_REG_DIR  = $clog2(NUM_REGISTERS);
  localparam int NB  = NUM_REGISTERS * BYTES_PER_REG;
  localparam int BIW = (BYTES_PER_REG > 1) ?
                       $clog2(BYTES_PER_REG) : 1;
  localparam int PW  = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [SIZE_REG_DIR-1:0] reg_q, reg_d;
  logic [BIW-1:0]          byte_q, byte_d;
  logic [NB-1:0][7:0]      snap_q;
  logic [PW-1:0]           ptr;
  logic                    xfer;
  logic                    last_byte;
  logic                    last_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      reg_q   <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      byte_q  <= byte_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_q <= '0;
    end else if (state_q == LOAD) begin
      snap_q <= i_registers_debug;
    end
  end

  assign xfer      = (state_q == SEND) && tx.i_ready;
  assign last_byte = byte_q == BIW'(BYTES_PER_REG - 1);
  assign last_reg  = reg_q == SIZE_REG_DIR'(NUM_REGISTERS - 1);

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    byte_d  = byte_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) state_d = LOAD;
      end
      LOAD: begin
        state_d = SEND;
        reg_d   = '0;
        byte_d  = '0;
      end
      SEND: begin
        if (xfer) begin
          if (last_byte && last_reg) begin
            state_d = DONE;
            reg_d   = '0;
            byte_d  = '0;
          end else if (last_byte) begin
            byte_d = '0;
            reg_d  = reg_q + SIZE_REG_DIR'(1);
          end else begin
            byte_d = byte_q + BIW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort outranks everything, including a same-cycle transfer.
    if (i_abort) begin
      state_d = IDLE;
      reg_d   = '0;
      byte_d  = '0;
    end
  end

  always_comb begin
    ptr = PW'(reg_q) * PW'(BYTES_PER_REG) + PW'(byte_q);
  end

  // Outputs decode only flopped state, never i_ready.
  assign tx.o_valid = state_q == SEND;
  assign tx.o_data  = (state_q == SEND) ? snap_q[ptr] : 8'h00;
  assign o_busy     = (state_q == LOAD) || (state_q == SEND);
  assign o_done     = state_q == DONE;
  assign o_reg_idx  = (state_q == SEND) ? reg_q : '0;

endmodule
